// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: counter indices,
// read-port address layout and read FSM states.
package perf_pkg;

  localparam int PERF_NUM_CNT = 8;
  localparam int PERF_ADDR_W  = 4;

  typedef enum logic [2:0] {
    CYCLE     = 3'd0,
    INSTR     = 3'd1,
    IC_ACCESS = 3'd2,
    IC_HIT    = 3'd3,
    IC_MISS   = 3'd4,
    LSU_LOAD  = 3'd5,
    LSU_STORE = 3'd6,
    LSU_WAIT  = 3'd7
  } perf_idx_e;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  // Read address is {counter_idx, hi_word}
  function automatic logic [2:0] perf_addr_idx(input logic [PERF_ADDR_W-1:0] addr);
    return addr[PERF_ADDR_W-1:1];
  endfunction

  function automatic logic perf_addr_hi(input logic [PERF_ADDR_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/perf_counter_slice.sv
// One free-running event counter with clear and modulo-2^CNT_W wrap.
// Sticky overflow flag only when PERF_OVF_IRQ_EN is defined.
module perf_counter_slice
  import perf_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
`ifdef PERF_OVF_IRQ_EN
  ,
  output logic             ovf
`endif
);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

`ifdef PERF_OVF_IRQ_EN
  logic ovf_r;

  // Sticky flag set on the increment that takes all-ones back to zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_r <= 1'b0;
    end else if (clr) begin
      ovf_r <= 1'b0;
    end else if (inc && (&cnt_r)) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// Eight NPC performance counters with a valid/ready 32-bit read port.
// Define PERF_OVF_IRQ_EN to add per-counter overflow flags and ovf_irq.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ifu_valid,
  input  logic                   icache_start,
  input  logic                   icache_valid,
  input  logic                   icache_isHit,
  input  logic                   lsu_ren,
  input  logic                   lsu_wen,
  input  logic                   lsu_isWaiting,
  input  logic                   clr,
  input  logic                   rd_req_valid,
  output logic                   rd_req_ready,
  input  logic [PERF_ADDR_W-1:0] rd_addr,
  output logic                   rd_resp_valid,
  input  logic                   rd_resp_ready,
  output logic [31:0]            rd_resp_data
`ifdef PERF_OVF_IRQ_EN
  ,
  output logic                   ovf_irq
`endif
);

  logic [PERF_NUM_CNT-1:0] inc_s;
  logic [CNT_W-1:0]        cnt_s [PERF_NUM_CNT];

  logic icache_start_q_r;
  logic icache_valid_q_r;
  logic lsu_wait_q_r;

  rd_state_e   rd_state_r;
  logic        rd_resp_valid_r;
  logic [31:0] rd_resp_data_r;
  logic [31:0] shadow_r;

  logic        rd_req_ready_s;
  logic        rd_accept_s;
  logic [2:0]  rd_idx_s;
  logic        rd_hi_s;
  logic [31:0] lo_word_s;
  logic [31:0] hi_live_s;
  logic [31:0] rd_word_s;

  // Previous-cycle copies of the level inputs used for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      icache_start_q_r <= 1'b0;
      icache_valid_q_r <= 1'b0;
      lsu_wait_q_r     <= 1'b0;
    end else begin
      icache_start_q_r <= icache_start;
      icache_valid_q_r <= icache_valid;
      lsu_wait_q_r     <= lsu_isWaiting;
    end
  end

  // Per-counter increment strobes
  always_comb begin
    inc_s            = '0;
    inc_s[CYCLE]     = 1'b1;
    inc_s[INSTR]     = ifu_valid;
    inc_s[IC_ACCESS] = icache_start & ~icache_start_q_r;
    inc_s[IC_HIT]    = icache_valid & ~icache_valid_q_r & icache_isHit;
    inc_s[IC_MISS]   = icache_valid & ~icache_valid_q_r & ~icache_isHit;
    inc_s[LSU_LOAD]  = ~lsu_isWaiting & lsu_wait_q_r & lsu_ren;
    inc_s[LSU_STORE] = ~lsu_isWaiting & lsu_wait_q_r & lsu_wen;
    inc_s[LSU_WAIT]  = lsu_isWaiting;
  end

`ifdef PERF_OVF_IRQ_EN
  logic [PERF_NUM_CNT-1:0] ovf_s;
  logic                    ovf_irq_r;
`endif

  for (genvar i = 0; i < PERF_NUM_CNT; i++) begin : g_slice
    perf_counter_slice #(
      .CNT_W(CNT_W)
    ) u_slice (
      .clk  (clk),
      .reset(reset),
      .inc  (inc_s[i]),
      .clr  (clr),
      .cnt  (cnt_s[i])
`ifdef PERF_OVF_IRQ_EN
      ,
      .ovf  (ovf_s[i])
`endif
    );
  end

`ifdef PERF_OVF_IRQ_EN
  // Interrupt is the registered OR of all sticky flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_irq_r <= 1'b0;
    end else if (clr) begin
      ovf_irq_r <= 1'b0;
    end else begin
      ovf_irq_r <= |ovf_s;
    end
  end

  assign ovf_irq = ovf_irq_r;
`endif

  // Read word selection; counter outputs are registers, so this is the pre-update value
  always_comb begin
    rd_idx_s  = perf_addr_idx(rd_addr);
    rd_hi_s   = perf_addr_hi(rd_addr);
    lo_word_s = cnt_s[rd_idx_s][31:0];
    hi_live_s = 32'(cnt_s[rd_idx_s] >> 32);
    if (rd_hi_s) begin
      rd_word_s = shadow_r;
    end else begin
      rd_word_s = lo_word_s;
    end
  end

  assign rd_req_ready_s = (rd_state_r == RD_IDLE) || rd_resp_ready;
  assign rd_accept_s    = rd_req_valid && rd_req_ready_s;

  // Read FSM: one response slot, refilled in the cycle it drains
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_state_r      <= RD_IDLE;
      rd_resp_valid_r <= 1'b0;
      rd_resp_data_r  <= 32'd0;
    end else begin
      case (rd_state_r)
        RD_IDLE: begin
          if (rd_accept_s) begin
            rd_state_r      <= RD_RESP;
            rd_resp_valid_r <= 1'b1;
            rd_resp_data_r  <= rd_word_s;
          end else begin
            rd_state_r      <= RD_IDLE;
            rd_resp_valid_r <= 1'b0;
          end
        end
        RD_RESP: begin
          if (rd_accept_s) begin
            rd_state_r      <= RD_RESP;
            rd_resp_valid_r <= 1'b1;
            rd_resp_data_r  <= rd_word_s;
          end else if (rd_resp_ready) begin
            rd_state_r      <= RD_IDLE;
            rd_resp_valid_r <= 1'b0;
          end else begin
            rd_state_r      <= RD_RESP;
            rd_resp_valid_r <= 1'b1;
          end
        end
        default: begin
          rd_state_r      <= RD_IDLE;
          rd_resp_valid_r <= 1'b0;
          rd_resp_data_r  <= 32'd0;
        end
      endcase
    end
  end

  // Upper-word snapshot taken by each accepted lo read, so lo-then-hi is atomic
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_r <= 32'd0;
    end else if (clr) begin
      shadow_r <= 32'd0;
    end else if (rd_accept_s && !rd_hi_s) begin
      shadow_r <= hi_live_s;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  assign rd_req_ready  = rd_req_ready_s;
  assign rd_resp_valid = rd_resp_valid_r;
  assign rd_resp_data  = rd_resp_data_r;

endmodule
